// File: rtl/jtag_master_pkg.sv
// Shared definitions for the JTAG initiator: op codes, FSM encoding and TMS walk constants.
package jtag_master_pkg;

    typedef enum logic [1:0] {
        OP_RESET = 2'd0,
        OP_IR    = 2'd1,
        OP_DR    = 2'd2,
        OP_WAIT  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_AUTO_RST = 3'd0,
        ST_READY    = 3'd1,
        ST_PRE      = 3'd2,
        ST_SHIFT    = 3'd3,
        ST_POST     = 3'd4,
        ST_WAIT     = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    // TMS sequences are stored LSB-first: bit 0 goes out in the first TCK period.
    localparam logic [3:0] IR_PREFIX = 4'b0011;
    localparam logic [2:0] DR_PREFIX = 3'b001;
    localparam logic [1:0] SUFFIX    = 2'b01;
    localparam logic [5:0] RST_LAST  = 6'd5;

    function automatic logic prefix_tms(input op_e op, input logic [5:0] idx);
        logic [3:0] dr_pad;
        dr_pad = {1'b0, DR_PREFIX};
        case (op)
            OP_IR:   return IR_PREFIX[idx[1:0]];
            OP_DR:   return dr_pad[idx[1:0]];
            default: return idx < RST_LAST;
        endcase
    endfunction

    function automatic logic [5:0] prefix_last(input op_e op);
        case (op)
            OP_IR:   return 6'd3;
            OP_DR:   return 6'd2;
            default: return RST_LAST;
        endcase
    endfunction

endpackage

// File: rtl/jtag_master_tck_gen.sv
// TCK divider: half-period of CLK_DIV clk cycles, with strobes on the cycle before each edge.
module tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q;
    logic          tck_q;
    logic          wrap;

    assign wrap   = en_i && (cnt_q == CW'(CLK_DIV - 1));
    assign rise_o = wrap && !tck_q;
    assign fall_o = wrap && tck_q;
    assign tck_o  = tck_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= wrap ? '0 : cnt_q + 1'b1;
            if (wrap) tck_q <= ~tck_q;
        end
    end

endmodule

// File: rtl/jtag_master.sv
// JTAG initiator: walks the TAP through reset, IR/DR scans and idle waits, one command at a time.
module jtag_master #(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               TCK,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO
);
    import jtag_master_pkg::*;

    localparam int         IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [5:0] MAX_LEN6 = 6'(MAX_LEN);

    state_e             state_q, state_d;
    op_e                op_q;
    logic [5:0]         bit_q, len_q;
    logic               fin_q;
    logic [MAX_LEN-1:0] data_q, rsp_q;
    logic               tck_rise, tck_fall, tck_en, accept, last_bit, final_phase;

    function automatic logic [5:0] scan_len(input logic [5:0] len);
        if (len == 6'd0) return 6'd1;
        if (len > MAX_LEN6) return MAX_LEN6;
        return len;
    endfunction

    // fin_q marks the one idle-TCK cycle after the last falling edge of a sequence.
    assign accept   = (state_q == ST_READY) && cmd_valid;
    assign tck_en   = !fin_q && (state_q inside {ST_AUTO_RST, ST_PRE, ST_SHIFT, ST_POST, ST_WAIT});
    assign rsp_data = rsp_q;

    tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (tck_en),
        .tck_o  (TCK),
        .rise_o (tck_rise),
        .fall_o (tck_fall)
    );

    always_comb begin
        last_bit    = 1'b0;
        final_phase = 1'b0;
        case (state_q)
            ST_AUTO_RST: begin last_bit = (bit_q == RST_LAST);            final_phase = 1'b1; end
            ST_PRE:      begin last_bit = (bit_q == prefix_last(op_q));   final_phase = (op_q == OP_RESET); end
            ST_SHIFT:          last_bit = (bit_q == len_q - 6'd1);
            ST_POST:     begin last_bit = (bit_q == 6'd1);                final_phase = 1'b1; end
            ST_WAIT:     begin last_bit = (bit_q == len_q - 6'd1);        final_phase = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_AUTO_RST;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_AUTO_RST: if (fin_q) state_d = ST_READY;
            ST_READY:    if (cmd_valid) state_d = (op_e'(cmd_op) == OP_WAIT) ? ST_WAIT : ST_PRE;
            ST_PRE: begin
                if (fin_q) state_d = ST_DONE;
                else if (tck_fall && last_bit && op_q != OP_RESET) state_d = ST_SHIFT;
            end
            ST_SHIFT:    if (tck_fall && last_bit) state_d = ST_POST;
            ST_POST:     if (fin_q) state_d = ST_DONE;
            ST_WAIT:     if (fin_q) state_d = ST_DONE;
            ST_DONE:     state_d = ST_READY;
            default:     state_d = ST_AUTO_RST;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_READY);
        busy      = (state_q != ST_READY);
        rsp_valid = (state_q == ST_DONE);
        TMS       = 1'b0;
        TDI       = 1'b0;
        case (state_q)
            ST_AUTO_RST: TMS = prefix_tms(OP_RESET, bit_q);
            ST_PRE:      TMS = prefix_tms(op_q, bit_q);
            ST_SHIFT:    begin TMS = last_bit; TDI = data_q[0]; end
            ST_POST:     TMS = SUFFIX[bit_q[0]];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_RESET;
            len_q  <= '0;
            bit_q  <= '0;
            fin_q  <= 1'b0;
            data_q <= '0;
            rsp_q  <= '0;
        end else if (accept) begin
            op_q   <= op_e'(cmd_op);
            len_q  <= (op_e'(cmd_op) == OP_WAIT) ? cmd_len : scan_len(cmd_len);
            bit_q  <= '0;
            fin_q  <= (op_e'(cmd_op) == OP_WAIT) && (cmd_len == 6'd0);
            data_q <= cmd_data;
            rsp_q  <= '0;
        end else if (fin_q) begin
            fin_q <= 1'b0;
            bit_q <= '0;
        end else if (tck_en) begin
            if (state_q == ST_SHIFT && tck_rise) rsp_q[bit_q[IW-1:0]] <= TDO;
            if (tck_fall) begin
                if (state_q == ST_SHIFT) data_q <= data_q >> 1;
                if (!last_bit)        bit_q <= bit_q + 6'd1;
                else if (final_phase) fin_q <= 1'b1;
                else                  bit_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: directed and random commands against a sequence-level TAP walk model.
module tb_jtag_master;

    localparam int D  = 4;
    localparam int ML = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [5:0]    cmd_len = 6'd0;
    logic [ML-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic [ML-1:0] rsp_data;
    logic          busy, TCK, TMS, TDI, TDO;

    int n_cmp = 0;
    int n_bad = 0;

    // Target side: TDO is either 0, a loopback of TDI, or bit p of tdo_vec in TCK period p.
    int           fall_tot = 0;
    int           pbase = 0;
    int           tdo_mode = 0;
    logic [127:0] tdo_vec = '0;
    logic         rtms[$];
    logic         rtdi[$];

    logic         exp_tms[$];
    logic         exp_tdi[$];
    logic [31:0]  exp_rsp;
    int           exp_lat;

    jtag_master #(.CLK_DIV(D), .MAX_LEN(ML)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .TCK       (TCK),
        .TMS       (TMS),
        .TDI       (TDI),
        .TDO       (TDO)
    );

    always #5 clk = ~clk;

    always @(posedge TCK) begin
        rtms.push_back(TMS);
        rtdi.push_back(TDI);
    end

    always @(negedge TCK) fall_tot++;

    assign TDO = (tdo_mode == 1) ? TDI :
                 (tdo_mode == 2) ? tdo_vec[7'(fall_tot - pbase)] : 1'b0;

    task automatic build_exp(input int op, input int len, input logic [31:0] data, input int mode);
        int eff, pre;
        exp_tms.delete();
        exp_tdi.delete();
        exp_rsp = '0;
        if (op == 3)         eff = len;
        else if (len == 0)   eff = 1;
        else if (len > ML)   eff = ML;
        else                 eff = len;
        pre = (op == 1) ? 4 : 3;
        case (op)
            0: for (int i = 0; i < 6; i++) begin
                   exp_tms.push_back(1'(i < 5));
                   exp_tdi.push_back(1'b0);
               end
            3: for (int i = 0; i < eff; i++) begin
                   exp_tms.push_back(1'b0);
                   exp_tdi.push_back(1'b0);
               end
            default: begin
                exp_tms.push_back(1'b1);
                if (op == 1) exp_tms.push_back(1'b1);
                exp_tms.push_back(1'b0);
                exp_tms.push_back(1'b0);
                for (int i = 0; i < pre; i++) exp_tdi.push_back(1'b0);
                for (int i = 0; i < eff; i++) begin
                    exp_tms.push_back(1'(i == eff - 1));
                    exp_tdi.push_back(data[i]);
                    if (mode == 1)      exp_rsp[i] = data[i];
                    else if (mode == 2) exp_rsp[i] = tdo_vec[pre + i];
                end
                exp_tms.push_back(1'b1);
                exp_tms.push_back(1'b0);
                exp_tdi.push_back(1'b0);
                exp_tdi.push_back(1'b0);
            end
        endcase
        exp_lat = exp_tms.size() * 2 * D + 2;
    endtask

    task automatic pack(input int rb, output int nr, output logic [127:0] gt, output logic [127:0] gd,
                        output logic [127:0] wt, output logic [127:0] wd);
        nr = rtms.size() - rb;
        gt = '0; gd = '0; wt = '0; wd = '0;
        for (int i = 0; i < nr && i < 128; i++) begin
            gt[i] = rtms[rb + i];
            gd[i] = rtdi[rb + i];
        end
        for (int i = 0; i < exp_tms.size(); i++) begin
            wt[i] = exp_tms[i];
            wd[i] = exp_tdi[i];
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                          output int lat, output bit to, output int rb, output logic r1);
        int n;
        to = 1'b0; lat = 0; r1 = 1'bx; rb = rtms.size();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
        n = 0;
        while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
        if (!cmd_ready) begin to = 1'b1; cmd_valid = 1'b0; return; end
        rb = rtms.size();
        pbase = fall_tot;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_len = 6'($urandom); cmd_data = $urandom;
        n = 0;
        do begin
            @(negedge clk); n++;
            if (n == 1) r1 = cmd_ready;
        end while (!rsp_valid && n < 1000);
        lat = n;
        to  = !rsp_valid;
    endtask

    task automatic test_reset();
        int  n;
        bit  saw;
        int  nr;
        logic [127:0] gt, gd, wt, wd;
        rst_n = 1'b0; tdo_mode = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({TCK, TMS, TDI, cmd_ready, busy, rsp_valid} !== 6'b010010) begin
            n_bad++;
            $display("FAIL reset_pins: got %b want 010010", {TCK, TMS, TDI, cmd_ready, busy, rsp_valid});
        end
        n_cmp++;
        if (rsp_data !== '0) begin n_bad++; $display("FAIL reset_rsp: got %h want 0", rsp_data); end
        exp_tms.delete(); exp_tdi.delete();
        for (int i = 0; i < 6; i++) begin exp_tms.push_back(1'(i < 5)); exp_tdi.push_back(1'b0); end
        nr = rtms.size();
        rst_n = 1'b1;
        n = 0; saw = 1'b0;
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; if (rsp_valid) saw = 1'b1; end
        pack(nr, nr, gt, gd, wt, wd);
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL autorst_ready: ready=%b busy=%b want 1/0", cmd_ready, busy);
        end
        n_cmp++;
        if (nr !== 6) begin n_bad++; $display("FAIL autorst_rises: got %0d want 6", nr); end
        n_cmp++;
        if (gt !== wt) begin n_bad++; $display("FAIL autorst_tms: got %h want %h", gt, wt); end
        n_cmp++;
        if (saw !== 1'b0) begin n_bad++; $display("FAIL autorst_rsp: rsp_valid seen=%b want 0", saw); end
    endtask

    task automatic test_scan(input string nm, input int op, input int len, input logic [31:0] data, input int mode);
        int lat, rb, nr;
        bit to;
        logic r1;
        logic [127:0] gt, gd, wt, wd;
        tdo_mode = mode;
        build_exp(op, len, data, mode);
        do_cmd(2'(op), 6'(len), data, lat, to, rb, r1);
        n_cmp++;
        if (to !== 1'b0) begin n_bad++; $display("FAIL %s timeout: no accept/response", nm); return; end
        pack(rb, nr, gt, gd, wt, wd);
        n_cmp++;
        if (nr !== exp_tms.size()) begin n_bad++; $display("FAIL %s rises: got %0d want %0d", nm, nr, exp_tms.size()); end
        n_cmp++;
        if (gt !== wt) begin n_bad++; $display("FAIL %s tms: got %h want %h", nm, gt, wt); end
        n_cmp++;
        if (gd !== wd) begin n_bad++; $display("FAIL %s tdi: got %h want %h", nm, gd, wd); end
        n_cmp++;
        if (rsp_data !== exp_rsp) begin n_bad++; $display("FAIL %s rsp: got %h want %h", nm, rsp_data, exp_rsp); end
        n_cmp++;
        if (lat !== exp_lat) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat); end
        n_cmp++;
        if (r1 !== 1'b0) begin n_bad++; $display("FAIL %s ready_drop: got %b want 0", nm, r1); end
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, cmd_ready} !== 2'b01 || rsp_data !== exp_rsp) begin
            n_bad++;
            $display("FAIL %s after: valid/ready=%b rsp=%h want 01 rsp=%h", nm, {rsp_valid, cmd_ready}, rsp_data, exp_rsp);
        end
    endtask

    task automatic test_reset_mid();
        int  n, nr;
        bit  saw;
        logic [127:0] gt, gd, wt, wd;
        tdo_mode = 2;
        tdo_vec = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 6'd32; cmd_data = $urandom;
        n = 0;
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        nr = rtms.size();
        pbase = fall_tot;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (rtms.size() - nr < 10 && n < 400) begin @(negedge clk); n++; end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({TCK, TMS, rsp_valid, cmd_ready, busy} !== 5'b01001) begin
            n_bad++; $display("FAIL midrst_pins: got %b want 01001", {TCK, TMS, rsp_valid, cmd_ready, busy});
        end
        tdo_mode = 0;
        exp_tms.delete(); exp_tdi.delete();
        for (int i = 0; i < 6; i++) begin exp_tms.push_back(1'(i < 5)); exp_tdi.push_back(1'b0); end
        @(negedge clk);
        nr = rtms.size();
        rst_n = 1'b1;
        n = 0; saw = 1'b0;
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; if (rsp_valid) saw = 1'b1; end
        repeat (3) begin @(negedge clk); if (rsp_valid) saw = 1'b1; end
        pack(nr, nr, gt, gd, wt, wd);
        n_cmp++;
        if (nr !== 6 || gt !== wt) begin
            n_bad++; $display("FAIL midrst_autorst: rises=%0d tms=%h want 6 tms=%h", nr, gt, wt);
        end
        n_cmp++;
        if (saw !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL midrst_end: rsp_seen=%b ready=%b want 0/1", saw, cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        int n, g, rb, nr, n2;
        logic [31:0] d1, d2;
        logic [127:0] gt, gd, wt, wd;
        tdo_mode = 1;
        d1 = $urandom; d2 = $urandom;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_len = 6'd3; cmd_data = d1;
        n = 0;
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        cmd_op = 2'd2; cmd_len = 6'd5; cmd_data = d2;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 1000);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== {29'd0, d1[2:0]}) begin
            n_bad++; $display("FAIL b2b_first: valid=%b rsp=%h want 1 rsp=%h", rsp_valid, rsp_data, {29'd0, d1[2:0]});
        end
        g = 1;
        @(negedge clk);
        if (!TCK) g++;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", cmd_ready); end
        rb = rtms.size();
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n2 = 0;
        @(negedge clk); n2++;
        n_cmp++;
        if ({cmd_ready, busy} !== 2'b01) begin n_bad++; $display("FAIL b2b_accept: ready/busy=%b want 01", {cmd_ready, busy}); end
        while (!TCK && g < 100) begin g++; @(negedge clk); n2++; end
        n_cmp++;
        if (g < 2) begin n_bad++; $display("FAIL b2b_gap: got %0d low cycles want >=2", g); end
        build_exp(2, 5, d2, 1);
        while (!rsp_valid && n2 < 1000) begin @(negedge clk); n2++; end
        pack(rb, nr, gt, gd, wt, wd);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_rsp || n2 !== exp_lat) begin
            n_bad++; $display("FAIL b2b_second: rsp=%h lat=%0d want rsp=%h lat=%0d", rsp_data, n2, exp_rsp, exp_lat);
        end
        n_cmp++;
        if (nr !== exp_tms.size() || gt !== wt || gd !== wd) begin
            n_bad++; $display("FAIL b2b_seq: rises=%0d tms=%h tdi=%h want %0d %h %h", nr, gt, gd, exp_tms.size(), wt, wd);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int op, len, mode;
        for (int k = 0; k < 16; k++) begin
            op   = $urandom_range(0, 3);
            len  = (op == 3) ? $urandom_range(0, 20) : $urandom_range(0, 40);
            mode = $urandom_range(1, 2);
            tdo_vec = {$urandom, $urandom, $urandom, $urandom};
            test_scan($sformatf("rand%0d", k), op, len, $urandom, mode);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scan("ir_loop", 1, 4, 32'h7, 1);
        tdo_vec = 128'(32'h1234_5678) << 3;
        test_scan("dr_idcode", 2, 32, 32'hA5A5_1234, 2);
        tdo_vec = {$urandom, $urandom, $urandom, $urandom};
        test_scan("dr_len0", 2, 0, $urandom, 2);
        tdo_vec = {$urandom, $urandom, $urandom, $urandom};
        test_scan("dr_len40", 2, 40, $urandom, 2);
        test_scan("wait0", 3, 0, $urandom, 0);
        test_scan("wait5", 3, 5, $urandom, 0);
        test_scan("tap_reset", 0, 17, $urandom, 1);
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
